// File: rtl/i2c_roic_target_if.sv
// rtl/i2c_roic_target_if.sv - I2C pin bundle between a bus master and the ROIC target
`timescale 1ns/1ps
interface i2c_roic_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_roic_target.sv
// rtl/i2c_roic_target.sv - I2C target with 16x8 register file and gate GPIO export
// Optional SCL/SDA 3-sample majority filter: I2C_ROIC_TARGET_GLITCH_FILTER_EN
`timescale 1ns/1ps
module i2c_roic_target #(
  parameter logic [6:0] SLAVE_ADDR7 = 7'h74,
  parameter logic [7:0] REG_RST_VAL = 8'h00
) (
  input  logic                    s_clk_25mhz,
  input  logic                    rst_n,
  i2c_roic_target_if.slave        i2c,
  output logic                    reg_wr_stb,
  output logic [3:0]              reg_wr_addr,
  output logic [7:0]              reg_wr_data,
  output logic [15:0]             gate_gpio_data,
  output logic                    busy
);
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA, ST_RACK, ST_IGNORE} state_e;
  typedef enum logic [1:0] {PH_RECV, PH_ACK_WAIT, PH_ACK_DRV} phase_e;

  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_p_q, scl_p_d, sda_p_q, sda_p_d;
  logic       scl_c, sda_c;
  state_e     state_q, state_d;
  phase_e     ph_q, ph_d;
  logic [3:0] bit_cnt_q, bit_cnt_d, ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic [7:0] shreg_q, shreg_d, txbyte_q, txbyte_d, wr_data_q, wr_data_d;
  logic       rw_q, rw_d, sda_oe_q, sda_oe_d, busy_q, busy_d, stb_q, stb_d;
  logic [15:0] gate_q, gate_d;
  logic [7:0] regs_q [16];
  logic [7:0] regs_d [16];

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;
  logic [3:0] ptr_inc;
  logic [2:0] tx_idx;

`ifdef I2C_ROIC_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  always_comb begin
    scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
    scl_filt_d = maj3(scl_hist_q);
    sda_filt_d = maj3(sda_hist_q);
  end

  always_ff @(posedge s_clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist_q <= 3'b111;
      sda_hist_q <= 3'b111;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
    end
  end

  assign scl_c = scl_filt_q;
  assign sda_c = sda_filt_q;
`else
  assign scl_c = scl_sync_q[1];
  assign sda_c = sda_sync_q[1];
`endif

  assign scl_rise  = scl_c & ~scl_p_q;
  assign scl_fall  = ~scl_c & scl_p_q;
  assign start_det = scl_c & scl_p_q & sda_p_q & ~sda_c;
  assign stop_det  = scl_c & scl_p_q & ~sda_p_q & sda_c;
  assign rx_byte   = {shreg_q[6:0], sda_c};
  assign ptr_inc   = ptr_q + 4'd1;
  assign tx_idx    = 3'd7 - bit_cnt_q[2:0];

  always_comb begin
    scl_sync_d = {scl_sync_q[0], i2c.scl_in};
    sda_sync_d = {sda_sync_q[0], i2c.sda_in};
    scl_p_d    = scl_c;
    sda_p_d    = sda_c;
    state_d    = state_q;
    ph_d       = ph_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    txbyte_d   = txbyte_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    stb_d      = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    regs_d     = regs_q;
    gate_d     = {regs_q[3], regs_q[2]};

    if (start_det) begin
      state_d   = ST_ADDR;
      ph_d      = PH_RECV;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      ph_d      = PH_RECV;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (ph_q == PH_RECV && scl_rise) begin
            shreg_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ph_d      = PH_ACK_WAIT;
              case (state_q)
                ST_ADDR: begin
                  if (rx_byte[7:1] == SLAVE_ADDR7) begin
                    rw_d = rx_byte[0];
                  end else begin
                    state_d = ST_IGNORE;
                    ph_d    = PH_RECV;
                  end
                end
                ST_PTR: ptr_d = rx_byte[3:0];
                default: begin
                  regs_d[ptr_q] = rx_byte;
                  stb_d         = 1'b1;
                  wr_addr_d     = ptr_q;
                  wr_data_d     = rx_byte;
                  ptr_d         = ptr_inc;
                end
              endcase
            end
          end else if (ph_q == PH_ACK_WAIT && scl_fall) begin
            sda_oe_d = 1'b1;
            ph_d     = PH_ACK_DRV;
          end else if (ph_q == PH_ACK_DRV && scl_fall) begin
            sda_oe_d = 1'b0;
            ph_d     = PH_RECV;
            // The fall ending the read-address ACK also launches the first data bit.
            if (state_q == ST_ADDR && rw_q) begin
              state_d   = ST_RDATA;
              txbyte_d  = regs_q[ptr_q];
              sda_oe_d  = ~regs_q[ptr_q][7];
              bit_cnt_d = 4'd1;
            end else if (state_q == ST_ADDR) begin
              state_d = ST_PTR;
            end else if (state_q == ST_PTR) begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (bit_cnt_q[3]) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RACK;
            end else begin
              sda_oe_d  = ~txbyte_q[tx_idx];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        ST_RACK: begin
          if (scl_rise) begin
            if (!sda_c) begin
              ptr_d     = ptr_inc;
              txbyte_d  = regs_q[ptr_inc];
              bit_cnt_d = 4'd0;
              state_d   = ST_RDATA;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_IGNORE: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge s_clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      state_q    <= ST_IDLE;
      ph_q       <= PH_RECV;
      bit_cnt_q  <= 4'd0;
      shreg_q    <= 8'h00;
      txbyte_q   <= 8'h00;
      ptr_q      <= 4'd0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      stb_q      <= 1'b0;
      wr_addr_q  <= 4'd0;
      wr_data_q  <= 8'h00;
      gate_q     <= 16'h0000;
      for (int i = 0; i < 16; i++) regs_q[i] <= REG_RST_VAL;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_p_q    <= scl_p_d;
      sda_p_q    <= sda_p_d;
      state_q    <= state_d;
      ph_q       <= ph_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      txbyte_q   <= txbyte_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      stb_q      <= stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      gate_q     <= gate_d;
      for (int i = 0; i < 16; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign i2c.sda_oe     = sda_oe_q;
  assign reg_wr_stb     = stb_q;
  assign reg_wr_addr    = wr_addr_q;
  assign reg_wr_data    = wr_data_q;
  assign gate_gpio_data = gate_q;
  assign busy           = busy_q;
endmodule

// File: tb/tb_i2c_roic_target.sv
// tb/tb_i2c_roic_target.sv - directed bench for i2c_roic_target
`timescale 1ns/1ps
module tb_i2c_roic_target;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_scl, m_sda;
  logic        reg_wr_stb;
  logic [3:0]  reg_wr_addr;
  logic [7:0]  reg_wr_data;
  logic [15:0] gate_gpio_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] stb_addr [$];
  logic [7:0] stb_data [$];

  always #20 clk = ~clk;

  i2c_roic_target_if bus ();
  assign bus.scl_in = m_scl;
  assign bus.sda_in = m_sda & ~bus.sda_oe;

  i2c_roic_target #(.SLAVE_ADDR7(7'h74), .REG_RST_VAL(8'h00)) dut (
    .s_clk_25mhz    (clk),
    .rst_n          (rst_n),
    .i2c            (bus),
    .reg_wr_stb     (reg_wr_stb),
    .reg_wr_addr    (reg_wr_addr),
    .reg_wr_data    (reg_wr_data),
    .gate_gpio_data (gate_gpio_data),
    .busy           (busy)
  );

  always @(negedge clk) begin
    if (reg_wr_stb) begin
      stb_addr.push_back(reg_wr_addr);
      stb_data.push_back(reg_wr_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic quarter();
    repeat (5) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; quarter();
    m_scl = 1'b1; quarter();
    m_sda = 1'b0; quarter();
    m_scl = 1'b0; quarter();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; quarter();
    m_scl = 1'b1; quarter();
    m_sda = 1'b1; quarter();
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    m_sda = b;
    if (glitch) begin
      repeat (2) @(negedge clk);
      m_scl = 1'b1;
      @(negedge clk);
      m_scl = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      quarter();
    end
    m_scl = 1'b1; quarter(); quarter();
    m_scl = 1'b0; quarter();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; quarter();
    m_scl = 1'b1; quarter();
    b = bus.sda_in; quarter();
    m_scl = 1'b0; quarter();
  endtask

  task automatic send_byte(input logic [7:0] d, input bit glitch_first, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], glitch_first && (i == 7));
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack, 1'b0);
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] d;
    int         base;
    logic [7:0] glitch_exp;

    m_scl = 1'b1;
    m_sda = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_sda_oe", bus.sda_oe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_stb", reg_wr_stb, 0);
    check_eq("rst_wr_addr", reg_wr_addr, 0);
    check_eq("rst_wr_data", reg_wr_data, 0);
    check_eq("rst_gate", gate_gpio_data, 16'h0000);
    rst_n = 1'b1;
    quarter();

    // Basic write to reg 2
    base = stb_addr.size();
    i2c_start();
    check_eq("t1_busy_start", busy, 1);
    send_byte(8'hE8, 1'b0, ack); check_eq("t1_ack_addr", ack, 0);
    send_byte(8'h02, 1'b0, ack); check_eq("t1_ack_ptr", ack, 0);
    send_byte(8'h5A, 1'b0, ack); check_eq("t1_ack_data", ack, 0);
    i2c_stop();
    check_eq("t1_busy_stop", busy, 0);
    check_eq("t1_stb_cnt", stb_addr.size() - base, 1);
    if (stb_addr.size() > base) begin
      check_eq("t1_stb_addr", stb_addr[base], 4'h2);
      check_eq("t1_stb_data", stb_data[base], 8'h5A);
    end
    check_eq("t1_gate", gate_gpio_data, 16'h005A);

    // Wrong address is NACKed and ignored
    base = stb_addr.size();
    i2c_start();
    send_byte(8'hE6, 1'b0, ack); check_eq("t2_nack_addr", ack, 1);
    send_byte(8'h02, 1'b0, ack);
    send_byte(8'h11, 1'b0, ack);
    i2c_stop();
    check_eq("t2_stb_cnt", stb_addr.size() - base, 0);
    check_eq("t2_gate", gate_gpio_data, 16'h005A);

    // Pointer wrap 15 -> 0
    base = stb_addr.size();
    i2c_start();
    send_byte(8'hE8, 1'b0, ack);
    send_byte(8'h0F, 1'b0, ack);
    send_byte(8'h11, 1'b0, ack);
    send_byte(8'h22, 1'b0, ack); check_eq("t3_ack_wrap", ack, 0);
    i2c_stop();
    check_eq("t3_stb_cnt", stb_addr.size() - base, 2);
    if (stb_addr.size() >= base + 2) begin
      check_eq("t3_addr0", stb_addr[base], 4'hF);
      check_eq("t3_data0", stb_data[base], 8'h11);
      check_eq("t3_addr1", stb_addr[base+1], 4'h0);
      check_eq("t3_data1", stb_data[base+1], 8'h22);
    end

    // Fill reg3/reg4, then pointer write + repeated START read
    i2c_start();
    send_byte(8'hE8, 1'b0, ack);
    send_byte(8'h03, 1'b0, ack);
    send_byte(8'hA5, 1'b0, ack);
    send_byte(8'h3C, 1'b0, ack);
    i2c_stop();
    check_eq("t4_gate", gate_gpio_data, 16'hA55A);
    i2c_start();
    send_byte(8'hE8, 1'b0, ack);
    send_byte(8'h03, 1'b0, ack);
    i2c_start();
    send_byte(8'hE9, 1'b0, ack); check_eq("t4_ack_rd_addr", ack, 0);
    recv_byte(1'b0, d); check_eq("t4_rd0", d, 8'hA5);
    recv_byte(1'b1, d); check_eq("t4_rd1", d, 8'h3C);
    check_eq("t4_sda_released", bus.sda_oe, 0);
    i2c_stop();
    check_eq("t4_busy_stop", busy, 0);

    // STOP in the middle of a data byte
    base = stb_addr.size();
    i2c_start();
    send_byte(8'hE8, 1'b0, ack);
    send_byte(8'h07, 1'b0, ack);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    i2c_stop();
    check_eq("t5_stb_cnt", stb_addr.size() - base, 0);
    check_eq("t5_busy", busy, 0);
    i2c_start();
    send_byte(8'hE8, 1'b0, ack); check_eq("t5_ack_after", ack, 0);
    send_byte(8'h07, 1'b0, ack);
    send_byte(8'h99, 1'b0, ack);
    i2c_stop();
    check_eq("t5_stb_cnt2", stb_addr.size() - base, 1);
    if (stb_addr.size() > base) check_eq("t5_data", stb_data[base], 8'h99);

    // 1-clock SCL glitch in the low phase before the first data bit
`ifdef I2C_ROIC_TARGET_GLITCH_FILTER_EN
    glitch_exp = 8'h5A;
`else
    glitch_exp = 8'h2D;
`endif
    base = stb_addr.size();
    i2c_start();
    send_byte(8'hE8, 1'b0, ack);
    send_byte(8'h05, 1'b0, ack);
    send_byte(8'h5A, 1'b1, ack);
    i2c_stop();
    check_eq("t6_stb_cnt", stb_addr.size() - base, 1);
    if (stb_addr.size() > base) begin
      check_eq("t6_addr", stb_addr[base], 4'h5);
      check_eq("t6_data", stb_data[base], glitch_exp);
    end

    // Reset while the target is pulling SDA for ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(logic'((8'hE8 >> i) & 1), 1'b0);
    m_sda = 1'b1;
    quarter();
    check_eq("t7_ack_driven", bus.sda_oe, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t7_rst_sda_oe", bus.sda_oe, 0);
    check_eq("t7_rst_gate", gate_gpio_data, 16'h0000);
    check_eq("t7_rst_busy", busy, 0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quarter();
    i2c_start();
    send_byte(8'hE8, 1'b0, ack);
    send_byte(8'h0F, 1'b0, ack);
    i2c_start();
    send_byte(8'hE9, 1'b0, ack); check_eq("t7_ack_rd", ack, 0);
    recv_byte(1'b1, d); check_eq("t7_reg15_cleared", d, 8'h00);
    i2c_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_roic_target.md
Name: i2c_roic_target

Overview:
- I2C target (responder) that models the ROIC register interface on the FPGA side.
- Answers a master issuing [addr+W][reg ptr][data...] writes and [addr+R] reads.
- Oversamples SCL/SDA with the 25MHz system clock and holds a 16x8 register file.
- Exports the gate GPIO word assembled from registers 0x02/0x03; used for loopback and as the on-board ROIC stand-in.

Parameters:
- SLAVE_ADDR7, 7'h74, 7-bit target address (write byte 0xE8, read byte 0xE9).
- REG_RST_VAL, 8'h00, reset value of every register.

Ports:
- s_clk_25mhz  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- scl_in  in  1  bus SCL (asynchronous).
- sda_in  in  1  bus SDA (asynchronous).
- sda_oe  out  1  1 = drive SDA low (open-drain); 0 = release.
- reg_wr_stb  out  1  one-cycle pulse per committed data byte.
- reg_wr_addr  out  4  register index of the committed byte.
- reg_wr_data  out  8  committed byte.
- gate_gpio_data  out  16  {reg[3], reg[2]}.
- busy  out  1  high from START until STOP.

Behaviour:
- Reset (async, rst_n=0): sda_oe=0, reg_wr_stb=0, reg_wr_addr=0, reg_wr_data=0, busy=0, all regs=REG_RST_VAL, gate_gpio_data=16'h0000, state=IDLE, ptr=0.
- Synchronisers: 2-FF on scl_in and sda_in, then a 1-cycle-delayed copy for edge detection.
- Edge definitions:
  - scl_rise / scl_fall: edges of synchronised SCL.
  - START: synchronised SDA falls while SCL is high.
  - STOP: synchronised SDA rises while SCL is high.
- START/STOP priority: both take priority over bit handling in the same cycle.
- START from any state (repeated START included): state=ADDR, bit_cnt=0, sda_oe=0, busy=1.
- STOP from any state: state=IDLE, sda_oe=0, busy=0. An incomplete byte is discarded with no strobe.
- Bit sampling: on scl_rise, shift sda into shreg MSB-first; bit_cnt++.
- Byte complete: on the 8th scl_rise.
- ACK: on the next scl_fall, drive sda_oe=1. Release on the following scl_fall.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - shreg[7:1]==SLAVE_ADDR7 -> ACK. R/W=0 goes to PTR; R/W=1 goes to RDATA.
    - No match -> NACK (sda_oe stays 0), go to IGNORE.
  - PTR: shift 8 bits; ptr = shreg[3:0] (upper bits ignored); ACK; go to WDATA.
  - WDATA: on the 8th scl_rise, the same cycle does all of the following:
    - reg[ptr] = shreg
    - reg_wr_stb=1 for exactly one cycle, with reg_wr_addr=ptr and reg_wr_data=shreg
    - ptr = ptr+1 (wraps 4'hF -> 4'h0)
    - then ACK and stay in WDATA.
  - RDATA:
    - Load txbyte=reg[ptr] on entry. Entry is the scl_fall that ends the address ACK.
    - Drive each bit on scl_fall: sda_oe = ~txbyte[7-bit].
    - After 8 bits, release on scl_fall and go to RACK.
  - RACK: sample master ACK on scl_rise.
    - SDA=0 -> ptr++ (wrap), reload txbyte, return to RDATA.
    - SDA=1 (NACK) -> IGNORE.
  - IGNORE: sda_oe=0; wait for START/STOP.
- Output timing:
  - gate_gpio_data is registered; it updates one cycle after the reg[2]/reg[3] write.
  - Latency from pin edge to internal edge: 3 clocks. Margin is sufficient at 1.25MHz SCL (10 clocks high / 10 low).
- SDA release: sda_oe never changes except on scl_fall, STOP/START, or reset. Reset mid-transfer releases SDA immediately.

Optional Feature:
- Macro I2C_ROIC_TARGET_GLITCH_FILTER_EN.
- Defined:
  - Synchronised SCL and SDA each pass through a 3-sample majority filter.
  - Pulses of 1 clock (<=40ns) are rejected.
  - Edge-detection latency becomes 5 clocks.
- Undefined:
  - Filter absent; 3-clock latency.
  - A single-cycle SCL glitch is treated as a real edge.

Test Plan:
- Write 0xE8,0x02,0x5A, STOP -> 3 ACKs; one reg_wr_stb with addr=2, data=0x5A; gate_gpio_data=0x005A; busy falls after STOP.
- Write 0xE6,0x02,0x11 -> no ACK on address byte, no reg_wr_stb, regs unchanged.
- Write 0xE8,0x0F,0x11,0x22 -> reg[15]=0x11, reg[0]=0x22; two strobes (addr 15 then 0).
- After reg[3]=0xA5, reg[4]=0x3C: write 0xE8,0x03, repeated START, 0xE9, read 2 bytes with master ACK then NACK -> reads 0xA5, 0x3C; sda_oe=0 after NACK.
- STOP after 4 data bits of a data byte -> no strobe, state IDLE; rst_n low while sda_oe=1 during ACK -> sda_oe=0 the same cycle, all regs 0x00.
- Macro defined: 1-cycle high pulse on SCL mid-low-phase -> no bit shifted, transfer completes correctly; macro undefined -> byte corrupted/misaligned.
